// File: rtl/bp_cce_mmio_cfg_endpoint.sv
// Config-link MMIO slave: turns uncached CCE memory commands into core/CCE control-register
// and microcode-RAM accesses, one response per command. Optional macro: BP_CFG_DECODE_ERR_EN.
package bp_cce_mmio_cfg_pkg;

   typedef enum logic [1:0] {
      e_lce_mode_uncached = 2'd0,
      e_lce_mode_normal   = 2'd1,
      e_lce_mode_nonspec  = 2'd2
   } bp_lce_mode_e;

   typedef enum logic {
      e_cce_mode_uncached = 1'b0,
      e_cce_mode_normal   = 1'b1
   } bp_cce_mode_e;

   typedef enum logic [3:0] {
      e_cce_mem_rd    = 4'd0,
      e_cce_mem_wr    = 4'd1,
      e_cce_mem_uc_rd = 4'd2,
      e_cce_mem_uc_wr = 4'd3
   } bp_cce_mem_cmd_e;

   localparam logic [3:0]  cfg_dev_gp                   = 4'd2;
   localparam logic [31:0] bp_cfg_reg_reset_gp          = 32'h0000_0001;
   localparam logic [31:0] bp_cfg_reg_freeze_gp         = 32'h0000_0002;
   localparam logic [31:0] bp_cfg_reg_npc_gp            = 32'h0000_0003;
   localparam logic [31:0] bp_cfg_reg_icache_mode_gp    = 32'h0000_0004;
   localparam logic [31:0] bp_cfg_reg_dcache_mode_gp    = 32'h0000_0005;
   localparam logic [31:0] bp_cfg_reg_cce_mode_gp       = 32'h0000_0006;
   localparam logic [31:0] bp_cfg_mem_base_cce_ucode_gp = 32'h0000_8000;

endpackage

module bp_cce_mmio_cfg_endpoint
   import bp_cce_mmio_cfg_pkg::*;
   #(parameter int paddr_width_p         = 40
   , parameter int cce_block_width_p     = 64
   , parameter int lce_id_width_p        = 6
   , parameter int lce_max_assoc_p       = 8
   , parameter int cfg_addr_width_p      = 20
   , parameter int dword_width_p         = 64
   , parameter int vaddr_width_p         = 39
   , parameter int cce_id_width_p        = 6
   , parameter int inst_width_p          = 32
   , parameter int inst_ram_addr_width_p = 8
   , parameter int inst_ram_els_p        = 256
   , localparam int payload_width_lp     = lce_id_width_p + $clog2(lce_max_assoc_p)
   , localparam int header_width_lp      = 4 + paddr_width_p + 3 + payload_width_lp
   , localparam int cce_mem_msg_width_lp = header_width_lp + cce_block_width_p
   )
   (input  logic                              clk_i
   , input  logic                              reset_i
   , input  logic [cce_id_width_p-1:0]         cce_id_i
   , input  logic [cce_mem_msg_width_lp-1:0]   io_cmd_i
   , input  logic                              io_cmd_v_i
   , output logic                              io_cmd_yumi_o
   , output logic [cce_mem_msg_width_lp-1:0]   io_resp_o
   , output logic                              io_resp_v_o
   , input  logic                              io_resp_ready_i
   , output logic                              reset_o
   , output logic                              freeze_o
   , output bp_lce_mode_e                      icache_mode_o
   , output bp_lce_mode_e                      dcache_mode_o
   , output bp_cce_mode_e                      cce_mode_o
   , output logic [vaddr_width_p-1:0]          npc_o
   , output logic                              npc_w_v_o
   , output logic                              cce_ucode_v_o
   , output logic                              cce_ucode_w_o
   , output logic [inst_ram_addr_width_p-1:0]  cce_ucode_addr_o
   , output logic [inst_width_p-1:0]           cce_ucode_data_o
   , input  logic [inst_width_p-1:0]           cce_ucode_data_i
`ifdef BP_CFG_DECODE_ERR_EN
   , output logic                              decode_err_o
   , output logic [7:0]                        err_cnt_o
`endif
   );

   localparam int nonlocal_width_lp = paddr_width_p - cce_id_width_p - 4 - cfg_addr_width_p;
   localparam logic [31:0] ucode_lo_lp = bp_cfg_mem_base_cce_ucode_gp;
   localparam logic [31:0] ucode_hi_lp = bp_cfg_mem_base_cce_ucode_gp + 32'(inst_ram_els_p);

   typedef struct packed {
      logic [payload_width_lp-1:0] payload;
      logic [2:0]                  size;
      logic [paddr_width_p-1:0]    addr;
      logic [3:0]                  msg_type;
   } header_s;

   typedef struct packed {
      logic [cce_block_width_p-1:0] data;
      header_s                      header;
   } msg_s;

   typedef struct packed {
      logic [nonlocal_width_lp-1:0] nonlocal;
      logic [cce_id_width_p-1:0]    cce;
      logic [3:0]                   dev;
      logic [cfg_addr_width_p-1:0]  addr;
   } local_addr_s;

   typedef enum logic [1:0] {IDLE, EXEC, RD_WAIT, RESP} state_e;

   state_e                   state;
   msg_s                     cmd_r;
   local_addr_s              la;
   logic [dword_width_p-1:0] resp_data_r;
   logic                     resp_v_r;

   logic                     is_rd, is_wr, hit, is_ucode, reg_hit;
   logic                     sel_reset, sel_freeze, sel_npc, sel_icache, sel_dcache, sel_cce;
   logic [31:0]              addr_ext;
   logic [dword_width_p-1:0] reg_rdata;
   logic                     unused_data_bits;

   assign la = cmd_r.header.addr;

   always_comb begin
      is_rd      = (cmd_r.header.msg_type == e_cce_mem_uc_rd);
      is_wr      = (cmd_r.header.msg_type == e_cce_mem_uc_wr);
      addr_ext   = 32'(la.addr);
      hit        = (la.nonlocal == '0) && (la.dev == cfg_dev_gp) && (la.cce == cce_id_i)
                   && (is_rd || is_wr);
      sel_reset  = hit && (addr_ext == bp_cfg_reg_reset_gp);
      sel_freeze = hit && (addr_ext == bp_cfg_reg_freeze_gp);
      sel_npc    = hit && (addr_ext == bp_cfg_reg_npc_gp);
      sel_icache = hit && (addr_ext == bp_cfg_reg_icache_mode_gp);
      sel_dcache = hit && (addr_ext == bp_cfg_reg_dcache_mode_gp);
      sel_cce    = hit && (addr_ext == bp_cfg_reg_cce_mode_gp);
      reg_hit    = sel_reset | sel_freeze | sel_npc | sel_icache | sel_dcache | sel_cce;
      is_ucode   = hit && (addr_ext >= ucode_lo_lp) && (addr_ext < ucode_hi_lp);
      reg_rdata  = '0;
      if (sel_reset)  reg_rdata = dword_width_p'(reset_o);
      if (sel_freeze) reg_rdata = dword_width_p'(freeze_o);
      if (sel_npc)    reg_rdata = dword_width_p'(npc_o);
      if (sel_icache) reg_rdata = dword_width_p'(icache_mode_o);
      if (sel_dcache) reg_rdata = dword_width_p'(dcache_mode_o);
      if (sel_cce)    reg_rdata = dword_width_p'(cce_mode_o);
   end

   // Yumi is masked during reset so a command presented under reset is not silently eaten.
   assign io_cmd_yumi_o    = (state == IDLE) && io_cmd_v_i && !reset_i;
   assign npc_w_v_o        = (state == EXEC) && sel_npc && is_wr;
   assign cce_ucode_v_o    = (state == EXEC) && is_ucode;
   assign cce_ucode_w_o    = is_wr;
   assign cce_ucode_addr_o = inst_ram_addr_width_p'(addr_ext - ucode_lo_lp);
   assign cce_ucode_data_o = cmd_r.data[0+:inst_width_p];
   assign io_resp_v_o      = resp_v_r;
   assign io_resp_o        = {cce_block_width_p'(resp_data_r), cmd_r.header};

   // Write data above the widest register/instruction is don't-care.
   assign unused_data_bits = ^cmd_r.data;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state         <= IDLE;
         resp_v_r      <= 1'b0;
         reset_o       <= 1'b0;
         freeze_o      <= 1'b1;
         icache_mode_o <= e_lce_mode_uncached;
         dcache_mode_o <= e_lce_mode_uncached;
         cce_mode_o    <= e_cce_mode_uncached;
         npc_o         <= '0;
      end else begin
         case (state)
            IDLE: if (io_cmd_yumi_o) state <= EXEC;
            EXEC: begin
               if (is_wr) begin
                  if (sel_reset)  reset_o       <= cmd_r.data[0];
                  if (sel_freeze) freeze_o      <= cmd_r.data[0];
                  if (sel_npc)    npc_o         <= cmd_r.data[0+:vaddr_width_p];
                  if (sel_icache) icache_mode_o <= bp_lce_mode_e'(cmd_r.data[1:0]);
                  if (sel_dcache) dcache_mode_o <= bp_lce_mode_e'(cmd_r.data[1:0]);
                  if (sel_cce)    cce_mode_o    <= bp_cce_mode_e'(cmd_r.data[0]);
               end
               if (is_ucode && is_rd) begin
                  state <= RD_WAIT;
               end else begin
                  state    <= RESP;
                  resp_v_r <= 1'b1;
               end
            end
            RD_WAIT: begin
               state    <= RESP;
               resp_v_r <= 1'b1;
            end
            RESP: if (io_resp_ready_i) begin
               state    <= IDLE;
               resp_v_r <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Captured command and read data carry no reset; they are only observed behind resp_v_r.
   always_ff @(posedge clk_i) begin
      if (io_cmd_yumi_o) cmd_r <= io_cmd_i;
      if (state == EXEC)
         resp_data_r <= (reg_hit && is_rd) ? reg_rdata : '0;
      else if (state == RD_WAIT)
         resp_data_r <= dword_width_p'(cce_ucode_data_i);
   end

`ifdef BP_CFG_DECODE_ERR_EN
   logic decode_miss;
   assign decode_miss = !(reg_hit || is_ucode);

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         decode_err_o <= 1'b0;
         err_cnt_o    <= '0;
      end else if ((state == EXEC) && decode_miss) begin
         decode_err_o <= 1'b1;
         err_cnt_o    <= sat_inc(err_cnt_o);
      end
   end
`endif

endmodule
